// File: rtl/math_game_pkg.sv
// math_game_pkg: shared state encodings and ALU opcode/operand-select constants
// for the binary math game round controller and its datapath.
package math_game_pkg;
    typedef enum logic [4:0] {
        LOAD_A   = 5'd0,
        LOAD_A_W = 5'd1,
        LOAD_B   = 5'd2,
        LOAD_B_W = 5'd3,
        LOAD_C   = 5'd4,
        LOAD_C_W = 5'd5,
        LOAD_X   = 5'd6,
        LOAD_X_W = 5'd7,
        CALC1    = 5'd8,
        CALC2    = 5'd9,
        CALC3    = 5'd10,
        CALC4    = 5'd11,
        CALC5    = 5'd12,
        ANSWER   = 5'd13,
        ANSWER_W = 5'd14,
        CHECK    = 5'd15,
        RESULT   = 5'd16,
        RESULT_W = 5'd17
    } state_t;
    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_MUL = 1'b1;
    localparam logic [1:0] SEL_A = 2'd0;
    localparam logic [1:0] SEL_B = 2'd1;
    localparam logic [1:0] SEL_C = 2'd2;
    localparam logic [1:0] SEL_X = 2'd3;
endpackage

// File: rtl/math_round_timer.sv
// math_round_timer: answer countdown; reloads on request, decrements on enabled
// ticks and flags expiry on the tick that takes it from 1 to 0.
module math_round_timer #(
    parameter int ROUND_TICKS = 30
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       i_reload,
    input  logic       i_dec,
    output logic [7:0] o_time_left,
    output logic       o_expire
);
    localparam logic [7:0] RELOAD = 8'(ROUND_TICKS);
    logic [7:0] r_time_left;
    assign o_time_left = r_time_left;
    assign o_expire    = i_dec && (r_time_left <= 8'd1);
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_time_left <= RELOAD;
        else if (i_reload)
            r_time_left <= RELOAD;
        else if (i_dec && r_time_left != 8'd0)
            r_time_left <= r_time_left - 8'd1;
    end
endmodule

// File: rtl/math_round_ctrl.sv
// math_round_ctrl: sequences a/b/c/x loading, r = a*x*x + b*x + c, answer check
// and scoring. Define MATH_ROUND_TIMEOUT_EN to enable the answer countdown.
module math_round_ctrl
    import math_game_pkg::*;
#(
    parameter int ROUND_TICKS = 30
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       go,
    input  logic [7:0] ans_in,
    input  logic [7:0] data_result,
    input  logic       tick,
    output logic       ld_a,
    output logic       ld_b,
    output logic       ld_c,
    output logic       ld_x,
    output logic       ld_alu_out,
    output logic       ld_r,
    output logic       alu_op,
    output logic [1:0] alu_select_a,
    output logic [1:0] alu_select_b,
    output logic       correct,
    output logic [7:0] cur_score,
    output logic [7:0] high_score,
    output logic [7:0] time_left,
    output logic [4:0] state_dbg
);
    state_t     r_state;
    logic [7:0] r_latch;
    logic       r_timeout;
    logic       r_correct;
    logic [7:0] r_cur;
    logic [7:0] r_high;
    logic       w_expire;
    logic       w_ok;
    logic       w_mul;
`ifdef MATH_ROUND_TIMEOUT_EN
    logic w_dec;
    assign w_dec = (r_state == ANSWER) && tick && !go;
    math_round_timer #(.ROUND_TICKS(ROUND_TICKS)) u_timer (
        .clk         (clk),
        .resetn      (resetn),
        .i_reload    (r_state == CALC5),
        .i_dec       (w_dec),
        .o_time_left (time_left),
        .o_expire    (w_expire)
    );
`else
    logic w_unused_tick;
    assign w_unused_tick = tick;
    assign time_left     = 8'(ROUND_TICKS);
    assign w_expire      = 1'b0;
`endif
    assign w_ok         = (r_latch == data_result) && !r_timeout;
    assign w_mul        = (r_state == CALC1) || (r_state == CALC2) || (r_state == CALC3);
    assign ld_a         = (r_state == LOAD_A && go) || r_state == CALC1 || r_state == CALC2 || r_state == CALC4;
    assign ld_b         = (r_state == LOAD_B && go) || r_state == CALC3;
    assign ld_c         = r_state == LOAD_C && go;
    assign ld_x         = r_state == LOAD_X && go;
    assign ld_alu_out   = w_mul || r_state == CALC4;
    assign ld_r         = r_state == CALC5;
    assign alu_op       = w_mul ? ALU_MUL : ALU_ADD;
    assign alu_select_a = (r_state == CALC3) ? SEL_B : SEL_A;
    assign alu_select_b = w_mul ? SEL_X : (r_state == CALC4) ? SEL_B : (r_state == CALC5) ? SEL_C : SEL_A;
    assign correct      = r_correct;
    assign cur_score    = r_cur;
    assign high_score   = r_high;
    assign state_dbg    = r_state;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= LOAD_A;
            r_latch   <= 8'd0;
            r_timeout <= 1'b0;
            r_correct <= 1'b0;
            r_cur     <= 8'd0;
            r_high    <= 8'd0;
        end else begin
            case (r_state)
                LOAD_A:   if (go) r_state <= LOAD_A_W;
                LOAD_A_W: if (!go) r_state <= LOAD_B;
                LOAD_B:   if (go) r_state <= LOAD_B_W;
                LOAD_B_W: if (!go) r_state <= LOAD_C;
                LOAD_C:   if (go) r_state <= LOAD_C_W;
                LOAD_C_W: if (!go) r_state <= LOAD_X;
                LOAD_X:   if (go) r_state <= LOAD_X_W;
                LOAD_X_W: if (!go) r_state <= CALC1;
                CALC1:    r_state <= CALC2;
                CALC2:    r_state <= CALC3;
                CALC3:    r_state <= CALC4;
                CALC4:    r_state <= CALC5;
                CALC5:    r_state <= ANSWER;
                ANSWER: begin
                    // a press beats a simultaneous expiry
                    if (go) begin
                        r_latch   <= ans_in;
                        r_timeout <= 1'b0;
                        r_state   <= ANSWER_W;
                    end else if (w_expire) begin
                        r_timeout <= 1'b1;
                        r_state   <= CHECK;
                    end
                end
                ANSWER_W: if (!go) r_state <= CHECK;
                CHECK: begin
                    r_correct <= w_ok;
                    if (w_ok) begin
                        r_cur <= (r_cur == 8'd255) ? r_cur : r_cur + 8'd1;
                    end else begin
                        r_high <= (r_cur > r_high) ? r_cur : r_high;
                        r_cur  <= 8'd0;
                    end
                    r_state <= RESULT;
                end
                RESULT:   if (go) r_state <= RESULT_W;
                RESULT_W: if (!go) r_state <= LOAD_A;
                default:  r_state <= LOAD_A;
            endcase
        end
    end
endmodule

// File: tb/tb_math_round_ctrl.sv
// tb_math_round_ctrl: randomized rounds against an arithmetic reference model,
// with a small datapath model driven by the controller's load/select outputs.
module tb_math_round_ctrl;
    import math_game_pkg::*;
    localparam int RT = 4;
    logic       clk = 0, resetn = 0, go = 0, tick = 0;
    logic [7:0] ans_in = 0, din = 0;
    logic [7:0] data_result;
    logic       ld_a, ld_b, ld_c, ld_x, ld_alu_out, ld_r, alu_op, correct;
    logic [1:0] alu_select_a, alu_select_b;
    logic [7:0] cur_score, high_score, time_left;
    logic [4:0] state_dbg;
    int checks = 0, errors = 0;
    int m_cur = 0, m_high = 0;
    int n_lda = 0, n_ldr = 0, n_ld = 0;
    logic [7:0] ra, rb, rc, rx, rr, sa, sb, alu;

    math_round_ctrl #(.ROUND_TICKS(RT)) dut (
        .clk(clk), .resetn(resetn), .go(go), .ans_in(ans_in), .data_result(data_result), .tick(tick),
        .ld_a(ld_a), .ld_b(ld_b), .ld_c(ld_c), .ld_x(ld_x), .ld_alu_out(ld_alu_out), .ld_r(ld_r),
        .alu_op(alu_op), .alu_select_a(alu_select_a), .alu_select_b(alu_select_b), .correct(correct),
        .cur_score(cur_score), .high_score(high_score), .time_left(time_left), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pick(input logic [1:0] s, input logic [7:0] a, b, c, x);
        return s == 2'd0 ? a : s == 2'd1 ? b : s == 2'd2 ? c : x;
    endfunction
    always_comb begin
        sa  = pick(alu_select_a, ra, rb, rc, rx);
        sb  = pick(alu_select_b, ra, rb, rc, rx);
        alu = alu_op ? 8'(sa * sb) : 8'(sa + sb);
    end
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ra <= 0; rb <= 0; rc <= 0; rx <= 0; rr <= 0;
        end else begin
            if (ld_a) ra <= ld_alu_out ? alu : din;
            if (ld_b) rb <= ld_alu_out ? alu : din;
            if (ld_c) rc <= din;
            if (ld_x) rx <= din;
            if (ld_r) rr <= alu;
        end
    end
    assign data_result = rr;
    always @(posedge clk) begin
        if (resetn) begin
            if (ld_a) n_lda <= n_lda + 1;
            if (ld_r) n_ldr <= n_ldr + 1;
            if (ld_a | ld_b | ld_c | ld_x | ld_r) n_ld <= n_ld + 1;
        end
    end

    function automatic logic [7:0] ref_res(input int a, b, c, x);
        int t;
        t = a * x * x + b * x + c;
        return t[7:0];
    endfunction
    task automatic model_upd(input bit ok);
        if (ok) m_cur = (m_cur < 255) ? m_cur + 1 : 255;
        else begin
            if (m_cur > m_high) m_high = m_cur;
            m_cur = 0;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic press();
        go = 1; cyc();
        go = 0; cyc();
    endtask
    task automatic load4(input logic [7:0] a, b, c, x);
        din = a; press();
        din = b; press();
        din = c; press();
        din = x; press();
    endtask
    // loads operands, runs CALC1..CALC5, answers and stops in RESULT
    task automatic play(input logic [7:0] a, b, c, x, ans, output logic [7:0] res, output int nldr);
        int s;
        s = n_ldr;
        load4(a, b, c, x);
        repeat (5) cyc();
        res  = data_result;
        nldr = n_ldr - s;
        ans_in = ans;
        press();
        cyc();
    endtask

    task automatic test_reset();
        #12;
        checks++; if (state_dbg !== 5'(LOAD_A)) begin errors++; $display("FAIL reset_state got %0d want %0d", state_dbg, LOAD_A); end
        checks++; if (correct !== 1'b0) begin errors++; $display("FAIL reset_correct got %b want 0", correct); end
        checks++; if (cur_score !== 8'd0 || high_score !== 8'd0) begin errors++; $display("FAIL reset_scores got %0d/%0d want 0/0", cur_score, high_score); end
        checks++; if (time_left !== 8'(RT)) begin errors++; $display("FAIL reset_time got %0d want %0d", time_left, RT); end
        @(negedge clk); resetn = 1;
        cyc();
        checks++; if (ld_a !== 1'b0 || state_dbg !== 5'(LOAD_A)) begin errors++; $display("FAIL idle_no_load got ld_a=%b st=%0d want 0/%0d", ld_a, state_dbg, LOAD_A); end
    endtask

    task automatic test_normal();
        logic [7:0] res; int nldr;
        play(2, 3, 4, 5, 69, res, nldr);
        model_upd(1);
        checks++; if (res !== 8'd69) begin errors++; $display("FAIL normal_result got %0d want 69", res); end
        checks++; if (nldr !== 1) begin errors++; $display("FAIL normal_ld_r got %0d want 1", nldr); end
        checks++; if (correct !== 1'b1 || cur_score !== 8'(m_cur)) begin errors++; $display("FAIL normal_verdict got %b/%0d want 1/%0d", correct, cur_score, m_cur); end
        press();
        checks++; if (state_dbg !== 5'(LOAD_A)) begin errors++; $display("FAIL normal_return got %0d want %0d", state_dbg, LOAD_A); end
    endtask

    task automatic test_streak();
        logic [7:0] res; int nldr;
        play(2, 3, 4, 5, 0, res, nldr); model_upd(0); press();
        for (int i = 0; i < 3; i++) begin
            logic [7:0] a, b, c, x;
            a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); x = 8'($urandom);
            play(a, b, c, x, ref_res(a, b, c, x), res, nldr); model_upd(1); press();
        end
        checks++; if (cur_score !== 8'd3 || high_score !== 8'd1) begin errors++; $display("FAIL streak_pre got %0d/%0d want 3/1", cur_score, high_score); end
        play(2, 3, 4, 5, 70, res, nldr); model_upd(0);
        checks++; if (correct !== 1'b0 || cur_score !== 8'(m_cur) || high_score !== 8'(m_high)) begin
            errors++; $display("FAIL streak_end got %b/%0d/%0d want 0/%0d/%0d", correct, cur_score, high_score, m_cur, m_high); end
        press();
    endtask

    task automatic test_overflow();
        logic [7:0] res; int nldr;
        play(16, 0, 0, 16, 0, res, nldr); model_upd(1);
        checks++; if (res !== 8'd0 || correct !== 1'b1) begin errors++; $display("FAIL overflow got res=%0d correct=%b want 0/1", res, correct); end
        press();
    endtask

    task automatic test_random();
        logic [7:0] res, a, b, c, x, ans, e; int nldr; bit ok;
        for (int i = 0; i < 10; i++) begin
            a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); x = 8'($urandom);
            e = ref_res(a, b, c, x);
            ans = $urandom_range(0, 1) ? e : 8'($urandom);
            ok = (ans == e);
            play(a, b, c, x, ans, res, nldr); model_upd(ok);
            checks++; if (res !== e) begin errors++; $display("FAIL rand_result[%0d] got %0d want %0d", i, res, e); end
            checks++; if (correct !== ok || cur_score !== 8'(m_cur) || high_score !== 8'(m_high)) begin
                errors++; $display("FAIL rand_score[%0d] got %b/%0d/%0d want %b/%0d/%0d", i, correct, cur_score, high_score, ok, m_cur, m_high); end
            press();
        end
    endtask

    task automatic test_saturate();
        logic [7:0] res; int nldr;
        for (int i = 0; i < 258; i++) begin
            play(0, 0, 0, 0, 0, res, nldr); model_upd(1); press();
        end
        checks++; if (cur_score !== 8'd255 || m_cur != 255) begin errors++; $display("FAIL saturate got %0d want 255", cur_score); end
    endtask

`ifdef MATH_ROUND_TIMEOUT_EN
    task automatic test_timeout();
        load4(1, 1, 1, 1); repeat (5) cyc();
        checks++; if (state_dbg !== 5'(ANSWER) || time_left !== 8'(RT)) begin errors++; $display("FAIL to_entry got st=%0d t=%0d want %0d/%0d", state_dbg, time_left, ANSWER, RT); end
        repeat (3) begin tick = 1; cyc(); tick = 0; cyc(); end
        checks++; if (state_dbg !== 5'(ANSWER) || time_left !== 8'd1) begin errors++; $display("FAIL to_count got st=%0d t=%0d want %0d/1", state_dbg, time_left, ANSWER); end
        tick = 1; cyc(); tick = 0;
        checks++; if (state_dbg !== 5'(CHECK)) begin errors++; $display("FAIL to_expire got %0d want %0d", state_dbg, CHECK); end
        cyc(); model_upd(0);
        checks++; if (correct !== 1'b0 || cur_score !== 8'(m_cur) || high_score !== 8'(m_high)) begin
            errors++; $display("FAIL to_verdict got %b/%0d/%0d want 0/%0d/%0d", correct, cur_score, high_score, m_cur, m_high); end
        press();
        load4(1, 1, 1, 1); repeat (5) cyc();
        repeat (3) begin tick = 1; cyc(); tick = 0; cyc(); end
        ans_in = ref_res(1, 1, 1, 1); go = 1; tick = 1; cyc(); tick = 0;
        checks++; if (state_dbg !== 5'(ANSWER_W)) begin errors++; $display("FAIL to_go_wins got %0d want %0d", state_dbg, ANSWER_W); end
        go = 0; cyc(); cyc(); model_upd(1);
        checks++; if (correct !== 1'b1 || cur_score !== 8'(m_cur)) begin errors++; $display("FAIL to_go_verdict got %b/%0d want 1/%0d", correct, cur_score, m_cur); end
        press();
    endtask
`else
    task automatic test_timeout();
        load4(1, 1, 1, 1); repeat (5) cyc();
        repeat (2 * RT) begin tick = 1; cyc(); tick = 0; cyc(); end
        checks++; if (state_dbg !== 5'(ANSWER) || time_left !== 8'(RT)) begin errors++; $display("FAIL no_timeout got st=%0d t=%0d want %0d/%0d", state_dbg, time_left, ANSWER, RT); end
        ans_in = ref_res(1, 1, 1, 1); press(); cyc(); model_upd(1);
        checks++; if (correct !== 1'b1 || cur_score !== 8'(m_cur)) begin errors++; $display("FAIL no_timeout_verdict got %b/%0d want 1/%0d", correct, cur_score, m_cur); end
        press();
    endtask
`endif

    task automatic test_held_key();
        int s;
        s = n_lda;
        din = 8'd9; go = 1; repeat (5) cyc();
        checks++; if (n_lda - s != 1 || state_dbg !== 5'(LOAD_A_W)) begin errors++; $display("FAIL held_key got ld_a=%0d st=%0d want 1/%0d", n_lda - s, state_dbg, LOAD_A_W); end
        go = 0; cyc();
        checks++; if (state_dbg !== 5'(LOAD_B)) begin errors++; $display("FAIL held_release got %0d want %0d", state_dbg, LOAD_B); end
    endtask

    task automatic test_reset_midop();
        int s;
        din = 1; press(); press(); press();
        cyc(); cyc();
        checks++; if (state_dbg !== 5'(CALC3)) begin errors++; $display("FAIL midop_reach got %0d want %0d", state_dbg, CALC3); end
        #2 resetn = 0; #1;
        m_cur = 0; m_high = 0;
        checks++; if (state_dbg !== 5'(LOAD_A) || cur_score !== 8'd0 || high_score !== 8'd0 || time_left !== 8'(RT)) begin
            errors++; $display("FAIL midop_reset got st=%0d %0d/%0d t=%0d want %0d 0/0 %0d", state_dbg, cur_score, high_score, time_left, LOAD_A, RT); end
        @(negedge clk); resetn = 1;
        s = n_ld;
        repeat (3) cyc();
        checks++; if (n_ld - s != 0 || state_dbg !== 5'(LOAD_A)) begin errors++; $display("FAIL midop_idle got ld=%0d st=%0d want 0/%0d", n_ld - s, state_dbg, LOAD_A); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_streak();
        test_overflow();
        test_random();
        test_saturate();
        test_timeout();
        test_held_key();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
